unidade_mult_div: RTL and testbench

Iterative multiply/divide unit with HI/LO result registers. It sits directly downstream of the register bank: its operands are the two register read ports (RS and RT contents). It executes MULT, MULTU, DIV and DIVU over multiple cycles, with a start/busy/done handshake. HI and LO are also writable directly (MTHI/MTLO) and are read continuously (MFHI/MFLO).

---
 rtl/unidade_mult_div.sv | 171 +++++++++++++++++
 tb/tb_unidade_mult_div.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_mult_div.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI/MTLO).
// Optional divide-by-zero status output enabled by defining MD_DIV_ZERO_FLAG_EN.
module unidade_mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandoA,
    input  logic [WIDTH-1:0] operandoB,
    input  logic             escreveHI,
    input  logic             escreveLO,
    input  logic [WIDTH-1:0] dadosEscrita,
    output logic             ocupado,
    output logic             pronto,
`ifdef MD_DIV_ZERO_FLAG_EN
    output logic             divZero,
`endif
    output logic [1:0]       o_estado,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    // Handshake: start is sampled only in IDLE; ocupado stays high from the start
    // edge until the result edge, where pronto pulses for exactly one cycle.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } estado_t;

    estado_t          r_estado;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_p_hi;
    logic [WIDTH-1:0] r_p_lo;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_a_orig;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_pronto;
    logic             r_ocupado;
`ifdef MD_DIV_ZERO_FLAG_EN
    logic             r_div_zero;
`endif

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    // op[0]=0 selects the signed variants; magnitudes make the datapath unsigned.
    assign w_a_neg = ~op[0] & operandoA[WIDTH-1];
    assign w_b_neg = ~op[0] & operandoB[WIDTH-1];
    assign w_a_mag = w_a_neg ? -operandoA : operandoA;
    assign w_b_mag = w_b_neg ? -operandoB : operandoB;

    assign w_mul_sum   = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    assign w_div_shift = {r_p_hi, r_p_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_m};

    assign w_prod     = {r_p_hi, r_p_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -r_p_lo : r_p_lo;
    assign w_rem      = r_neg_r ? -r_p_hi : r_p_hi;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado  <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_p_hi    <= '0;
            r_p_lo    <= '0;
            r_m       <= '0;
            r_a_orig  <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pronto  <= 1'b0;
            r_ocupado <= 1'b0;
`ifdef MD_DIV_ZERO_FLAG_EN
            r_div_zero <= 1'b0;
`endif
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                S_IDLE: begin
                    if (start) begin
                        r_op      <= op;
                        r_a_orig  <= operandoA;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_div0    <= op[1] && (operandoB == '0);
                        r_p_hi    <= '0;
                        // Multiply shifts the multiplier out of lo; divide shifts the dividend out of lo.
                        r_p_lo    <= op[1] ? w_a_mag : w_b_mag;
                        r_m       <= op[1] ? w_b_mag : w_a_mag;
                        r_cnt     <= CW'(WIDTH);
                        r_ocupado <= 1'b1;
                        r_estado  <= S_CALC;
`ifdef MD_DIV_ZERO_FLAG_EN
                        r_div_zero <= 1'b0;
`endif
                    end else begin
                        if (escreveHI) r_hi <= dadosEscrita;
                        if (escreveLO) r_lo <= dadosEscrita;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_op[1]) begin
                        if (!w_div_diff[WIDTH]) begin
                            r_p_hi <= w_div_diff[WIDTH-1:0];
                            r_p_lo <= {r_p_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_p_hi <= w_div_shift[WIDTH-1:0];
                            r_p_lo <= {r_p_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_p_hi <= w_mul_sum[WIDTH:1];
                        r_p_lo <= {w_mul_sum[0], r_p_lo[WIDTH-1:1]};
                    end
                    if (r_cnt == CW'(1)) r_estado <= S_FIX;
                end
                S_FIX: begin
                    if (!r_op[1]) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (r_div0) begin
                        r_hi <= r_a_orig;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
`ifdef MD_DIV_ZERO_FLAG_EN
                    r_div_zero <= r_div0;
`endif
                    r_pronto  <= 1'b1;
                    r_ocupado <= 1'b0;
                    r_estado  <= S_IDLE;
                end
                default: r_estado <= S_IDLE;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign pronto   = r_pronto;
    assign ocupado  = r_ocupado;
    assign o_estado = r_estado;
`ifdef MD_DIV_ZERO_FLAG_EN
    assign divZero  = r_div_zero;
`endif

endmodule

// File: tb/tb_unidade_mult_div.sv
// Randomized self-checking bench for unidade_mult_div against a plain-arithmetic reference model.
// Honours MD_DIV_ZERO_FLAG_EN when it is defined for the build.
module tb_unidade_mult_div;
    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clock;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operandoA;
    logic [W-1:0] operandoB;
    logic         escreveHI;
    logic         escreveLO;
    logic [W-1:0] dadosEscrita;
    logic         ocupado;
    logic         pronto;
    logic [1:0]   o_estado;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MD_DIV_ZERO_FLAG_EN
    logic         divZero;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    unidade_mult_div #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operandoA(operandoA), .operandoB(operandoB),
        .escreveHI(escreveHI), .escreveLO(escreveLO), .dadosEscrita(dadosEscrita),
        .ocupado(ocupado), .pronto(pronto),
`ifdef MD_DIV_ZERO_FLAG_EN
        .divZero(divZero),
`endif
        .o_estado(o_estado), .hi(hi), .lo(lo)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} from 64-bit integer arithmetic.
    function automatic logic [2*W-1:0] ref_model(input logic [1:0] f_op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [2*W-1:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = '0;
        case (f_op)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            2'b10: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // driver: one operation; a conflicting start + MTHI is injected at cycle 'poke' (if >= 0)
    task automatic run_op(input logic [1:0] t_op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke);
        logic [2*W-1:0] exp;
        int cycles;
        bit done;
        exp_q.push_back(ref_model(t_op, a, b));
        @(negedge clock);
        start = 1'b1; op = t_op; operandoA = a; operandoB = b;
        escreveHI = 1'b1; escreveLO = 1'b1; dadosEscrita = $urandom;
        @(negedge clock);
        start = 1'b0; escreveHI = 1'b0; escreveLO = 1'b0;
        check("ocupado_after_start", {31'b0, ocupado}, 1);
        check("hi_held_start_wins", hi, m_hi);
        check("lo_held_start_wins", lo, m_lo);
`ifdef MD_DIV_ZERO_FLAG_EN
        check("divzero_cleared", {31'b0, divZero}, 0);
`endif
        cycles = 0;
        done = 1'b0;
        while (!done && cycles < 100) begin
            if (cycles == poke) begin
                start = 1'b1; op = $urandom_range(0, 3);
                operandoA = $urandom; operandoB = $urandom;
                escreveHI = 1'b1; escreveLO = 1'b1; dadosEscrita = 32'hAAAA_5555;
            end
            @(negedge clock);
            cycles++;
            start = 1'b0; escreveHI = 1'b0; escreveLO = 1'b0;
            if (pronto) done = 1'b1;
            else if (!ocupado) check("ocupado_during_op", {31'b0, ocupado}, 1);
        end
        check("pronto_seen", {31'b0, done}, 1);
        exp = exp_q.pop_front();
        if (done) begin
            check("latency", cycles, LAT);
            check("hi_result", hi, exp[2*W-1:W]);
            check("lo_result", lo, exp[W-1:0]);
            check("ocupado_at_pronto", {31'b0, ocupado}, 0);
`ifdef MD_DIV_ZERO_FLAG_EN
            check("divzero_set", {31'b0, divZero}, {31'b0, (t_op[1] && b == 0)});
`endif
            m_hi = exp[2*W-1:W];
            m_lo = exp[W-1:0];
            @(negedge clock);
            check("pronto_one_cycle", {31'b0, pronto}, 0);
`ifdef MD_DIV_ZERO_FLAG_EN
            check("divzero_held", {31'b0, divZero}, {31'b0, (t_op[1] && b == 0)});
`endif
        end
    endtask

    task automatic mt_write(input bit wh, input bit wl, input logic [W-1:0] d);
        @(negedge clock);
        escreveHI = wh; escreveLO = wl; dadosEscrita = d;
        @(negedge clock);
        escreveHI = 1'b0; escreveLO = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
        check("mthi", hi, m_hi);
        check("mtlo", lo, m_lo);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int pulses;
        reset = 1'b1; start = 1'b0; op = 2'b00; operandoA = '0; operandoB = '0;
        escreveHI = 1'b0; escreveLO = 1'b0; dadosEscrita = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_pronto", {31'b0, pronto}, 0);
        check("reset_ocupado", {31'b0, ocupado}, 0);
`ifdef MD_DIV_ZERO_FLAG_EN
        check("reset_divzero", {31'b0, divZero}, 0);
`endif

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1);
        run_op(2'b11, 32'd100, 32'd0, -1);
        run_op(2'b01, 32'd6, 32'd7, 5);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, -1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, -1);

        mt_write(1'b0, 1'b1, 32'h1234_5678);
        mt_write(1'b1, 1'b1, 32'hCAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1);
        end

        // abort in flight: no result, everything back to reset values
        mt_write(1'b0, 1'b1, 32'h1234_5678);
        @(negedge clock);
        start = 1'b1; op = 2'b11; operandoA = 32'd9; operandoB = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_ocupado", {31'b0, ocupado}, 0);
        check("abort_pronto", {31'b0, pronto}, 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (pronto) pulses++;
        end
        check("abort_no_pronto", pulses, 0);
        check("abort_hi_hold", hi, 0);

        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
